// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-path controller.
package router_pkg;

    localparam int ADDR_W   = 2;
    localparam int NUM_DEST = 3;
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Out-of-range addresses select nothing, so they read back as 0.
    function automatic logic sel_bit(input logic [NUM_DEST-1:0] vec,
                                     input logic [ADDR_W-1:0]   addr);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (int'(addr) == i) r = vec[i];
        end
        return r;
    endfunction

    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_DEST;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Handshake bundle between the input port / register block / synchronizer and router_fsm.
interface router_fsm_if;
    import router_pkg::*;

    logic              pkt_valid;
    logic [ADDR_W-1:0] din;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;

    logic              detect_addr;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;

    modport master (
        output pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        input  detect_addr, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        output detect_addr, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// Packet-level Moore controller for the router input path: header decode, payload load,
// full-FIFO pause, parity check. All outputs decode directly from the state register.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for header; synchronizer latches din
// WAIT_TILL_EMPTY    | header addressed a non-empty FIFO; hold source
// LOAD_FIRST_DATA    | header byte written
// LOAD_DATA          | payload bytes streaming into FIFO
// FIFO_FULL_STATE    | destination full; writes blocked
// LOAD_AFTER_FULL    | write the byte held while full, then resume
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | register block compares parity and clears internals
module router_fsm
    import router_pkg::*;
(
    input logic         clk,
    input logic         rst,
    router_fsm_if.slave bus
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [NUM_DEST-1:0] empty_vec;
    logic [NUM_DEST-1:0] srst_vec;

    assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign srst_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && bus.pkt_valid) addr_q <= bus.din;
        end
    end

    always_comb begin
        state_nxt = state;
        // Timeout soft reset of the active destination aborts the packet from any busy state.
        if (state != DECODE_ADDRESS && sel_bit(srst_vec, addr_q)) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && addr_valid(bus.din)) begin
                        state_nxt = sel_bit(empty_vec, bus.din) ? LOAD_FIRST_DATA
                                                                : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_bit(empty_vec, addr_q)) state_nxt = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
                    else                        state_nxt = LOAD_DATA;
                end
                LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    assign bus.detect_addr   = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                               (state == LOAD_PARITY);
    assign bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: table of per-cycle vectors with a scoreboard queue,
// plus hand-written multi-cycle checks.
module tb_router_fsm;
    import router_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_fsm_if bus ();
    router_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        rst;
        logic        pv;
        logic [1:0]  din;
        logic        pd;
        logic        lpv;
        logic        full;
        logic [2:0]  emp;
        logic [2:0]  srst;
        state_t      exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         total = 0;
    int         bad   = 0;

    // {detect, lfd, ld, laf, full, wr_en, rst_int, busy} expected in a given state
    function automatic logic [7:0] exp_out(input state_t s);
        case (s)
            DECODE_ADDRESS:     return 8'b1000_0000;
            LOAD_FIRST_DATA:    return 8'b0100_0001;
            LOAD_DATA:          return 8'b0010_0100;
            LOAD_AFTER_FULL:    return 8'b0001_0101;
            FIFO_FULL_STATE:    return 8'b0000_1001;
            LOAD_PARITY:        return 8'b0000_0101;
            WAIT_TILL_EMPTY:    return 8'b0000_0001;
            CHECK_PARITY_ERROR: return 8'b0000_0011;
            default:            return 8'hxx;
        endcase
    endfunction

    function automatic logic [7:0] obs();
        return {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
    endfunction

    task automatic add(input logic r, input logic pv, input logic [1:0] din,
                       input logic pd, input logic lpv, input logic full,
                       input logic [2:0] emp, input logic [2:0] srst, input state_t exp);
        vec_t v;
        v.rst = r; v.pv = pv; v.din = din; v.pd = pd; v.lpv = lpv; v.full = full;
        v.emp = emp; v.srst = srst; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.pkt_valid     = v.pv;
        bus.din           = v.din;
        bus.parity_done   = v.pd;
        bus.low_pkt_valid = v.lpv;
        bus.fifo_full     = v.full;
        {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0} = v.emp;
        {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} = v.srst;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        vec_t v;
        v.rst = 0; v.pv = 0; v.din = 0; v.pd = 0; v.lpv = 0; v.full = 0;
        v.emp = 3'b111; v.srst = 3'b000; v.exp = DECODE_ADDRESS;
        drive(v);
    endtask

    initial begin
        logic [7:0] want;
        int         pulses;
        int         lfd_seen;
        int         waited;
        logic [1:0] bad_addr;

        bad_addr = INVALID_ADDR;

        // rst pv din pd lpv full emp srst -> state after the clock
        add(1,0,0,0,0,0,3'b111,3'b000,DECODE_ADDRESS);
        add(1,0,0,0,0,0,3'b111,3'b000,DECODE_ADDRESS);
        // normal packet to addr 1, four payload bytes
        add(0,1,1,0,0,0,3'b111,3'b000,LOAD_FIRST_DATA);
        add(0,1,1,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,1,1,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,1,1,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,1,1,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,0,1,0,0,0,3'b111,3'b000,LOAD_PARITY);
        add(0,0,1,0,0,0,3'b111,3'b000,CHECK_PARITY_ERROR);
        add(0,0,1,0,0,0,3'b111,3'b000,DECODE_ADDRESS);
        // addr 2 not empty for 5 clocks; din moved to 0 (whose FIFO is empty) while waiting
        add(0,1,2,0,0,0,3'b011,3'b000,WAIT_TILL_EMPTY);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0,0,3'b011,3'b000,WAIT_TILL_EMPTY);
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_FIRST_DATA);
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_DATA);
        // full for 3 clocks, then LAF with low_pkt_valid -> parity
        for (int i = 0; i < 3; i++) add(0,1,0,0,0,1,3'b111,3'b000,FIFO_FULL_STATE);
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_AFTER_FULL);
        add(0,0,0,0,1,0,3'b111,3'b000,LOAD_PARITY);
        add(0,0,0,0,0,0,3'b111,3'b000,CHECK_PARITY_ERROR);
        add(0,0,0,0,0,0,3'b111,3'b000,DECODE_ADDRESS);
        // LAF with neither flag -> LD; full beats !pkt_valid; parity_done beats low_pkt_valid
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_FIRST_DATA);
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,1,0,0,0,1,3'b111,3'b000,FIFO_FULL_STATE);
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_AFTER_FULL);
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,0,0,0,0,1,3'b111,3'b000,FIFO_FULL_STATE);
        add(0,0,0,0,0,0,3'b111,3'b000,LOAD_AFTER_FULL);
        add(0,0,0,1,1,0,3'b111,3'b000,DECODE_ADDRESS);
        // parity check with FIFO full -> full state
        add(0,1,1,0,0,0,3'b111,3'b000,LOAD_FIRST_DATA);
        add(0,0,1,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,0,1,0,0,0,3'b111,3'b000,LOAD_PARITY);
        add(0,0,1,0,0,0,3'b111,3'b000,CHECK_PARITY_ERROR);
        add(0,0,1,0,0,1,3'b111,3'b000,FIFO_FULL_STATE);
        add(0,0,1,0,0,0,3'b111,3'b000,LOAD_AFTER_FULL);
        add(0,0,1,1,0,0,3'b111,3'b000,DECODE_ADDRESS);
        // invalid address is dropped
        add(0,1,bad_addr,0,0,0,3'b111,3'b000,DECODE_ADDRESS);
        add(0,1,bad_addr,0,0,0,3'b111,3'b000,DECODE_ADDRESS);
        add(0,0,1,0,0,0,3'b111,3'b000,DECODE_ADDRESS);
        // soft reset: only the active destination's pulse counts
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_FIRST_DATA);
        add(0,1,0,0,0,0,3'b111,3'b000,LOAD_DATA);
        add(0,1,0,0,0,1,3'b111,3'b000,FIFO_FULL_STATE);
        add(0,1,0,0,0,1,3'b111,3'b010,FIFO_FULL_STATE);
        add(0,1,0,0,0,1,3'b111,3'b001,DECODE_ADDRESS);
        // soft reset is ignored in DECODE_ADDRESS
        add(0,0,0,0,0,0,3'b111,3'b001,DECODE_ADDRESS);
        add(0,1,1,0,0,0,3'b111,3'b001,LOAD_FIRST_DATA);
        add(0,1,1,0,0,0,3'b111,3'b001,LOAD_DATA);
        add(0,1,1,0,0,0,3'b111,3'b010,DECODE_ADDRESS);
        // hard reset mid-packet overrides everything
        add(0,1,1,0,0,0,3'b111,3'b000,LOAD_FIRST_DATA);
        add(1,1,1,0,0,1,3'b111,3'b010,DECODE_ADDRESS);

        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            sb_q.push_back(exp_out(vecs[i].exp));
            @(posedge clk);
            #1;
            want = sb_q.pop_front();
            check($sformatf("vec%0d", i), obs(), want);
        end

        // rst_int_reg must pulse exactly once for one packet to addr 2
        @(negedge clk);
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.din       = 2'd2;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) bus.pkt_valid = 1'b0;
            @(posedge clk);
            #1;
            if (bus.rst_int_reg) pulses++;
            @(negedge clk);
        end
        check("rst_int_pulse_count", 8'(pulses), 8'd1);

        // invalid header held for many clocks never loads
        idle_inputs();
        bus.pkt_valid = 1'b1;
        bus.din       = bad_addr;
        lfd_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.lfd_state || !bus.detect_addr) lfd_seen++;
        end
        check("invalid_hdr_never_loads", 8'(lfd_seen), 8'd0);

        // bounded wait: addr 0 held non-empty, then released
        @(negedge clk);
        bus.din = 2'd0;
        bus.fifo_empty_0 = 1'b0;
        @(posedge clk);
        #1;
        check("wait_entered", obs(), exp_out(WAIT_TILL_EMPTY));
        @(negedge clk);
        bus.fifo_empty_0 = 1'b1;
        waited = 0;
        while (!bus.lfd_state && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("wait_release_latency", 8'(waited), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
